// File: rtl/mbc_pkg.sv
// Shared encodings for the basic-computer control sequencer: register indices,
// bus sources, ALU operations, opcodes and register-reference micro-op bits.
package mbc_pkg;

    localparam int NUM_REGS = 5;
    localparam int REG_AR   = 0;
    localparam int REG_PC   = 1;
    localparam int REG_DR   = 2;
    localparam int REG_AC   = 3;
    localparam int REG_IR   = 4;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [2:0] ALU_NONE    = 3'd0;
    localparam logic [2:0] ALU_AND     = 3'd1;
    localparam logic [2:0] ALU_ADD     = 3'd2;
    localparam logic [2:0] ALU_LOAD_DR = 3'd3;
    localparam logic [2:0] ALU_CMA     = 3'd4;
    localparam logic [2:0] ALU_CIR     = 3'd5;
    localparam logic [2:0] ALU_CIL     = 3'd6;
    localparam logic [2:0] ALU_CME_CLE = 3'd7;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_LDA    = 3'd2;
    localparam logic [2:0] OP_STA    = 3'd3;
    localparam logic [2:0] OP_BUN    = 3'd4;
    localparam logic [2:0] OP_BSA    = 3'd5;
    localparam logic [2:0] OP_ISZ    = 3'd6;
    localparam logic [2:0] OP_REG_IO = 3'd7;

    localparam int UOP_CLA = 11;
    localparam int UOP_CLE = 10;
    localparam int UOP_CMA = 9;
    localparam int UOP_CME = 8;
    localparam int UOP_CIR = 7;
    localparam int UOP_CIL = 6;
    localparam int UOP_INC = 5;
    localparam int UOP_SPA = 4;
    localparam int UOP_SNA = 3;
    localparam int UOP_SZA = 2;
    localparam int UOP_SZE = 1;
    localparam int UOP_HLT = 0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } run_state_t;

endpackage

// File: rtl/control_sequencer_timing_decoder.sv
// Decodes the 4-bit sequence counter into one-hot timing signals T0..T15.
module timing_decoder (
    input  logic [3:0]  sc,
    output logic [15:0] t
);

    always_comb begin
        t     = '0;
        t[sc] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch/indirect/execute sequencing driven by SC,
// with a run/halted flag. All control outputs decode combinationally.
module control_sequencer
    import mbc_pkg::*;
#(
    parameter int n = 16
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         start,
    input  logic [n-1:0] ir_data,
    input  logic         ac_zero,
    input  logic         ac_sign,
    input  logic         dr_zero,
    input  logic         e_flag,
    output logic [4:0]   reg_write,
    output logic [4:0]   reg_inc,
    output logic [4:0]   reg_clear,
    output logic [2:0]   bus_select,
    output logic [2:0]   alu_op,
    output logic         mem_read,
    output logic         mem_write,
    output logic [3:0]   seq_count,
    output logic         halted
);

    run_state_t   state, state_next;
    logic [3:0]   sc, sc_next;
    logic [15:0]  t;
    logic         ind;
    logic [2:0]   d;
    logic [n-5:0] b;
    logic         t_bad;

    assign ind       = ir_data[n-1];
    assign d         = ir_data[n-2:n-4];
    assign b         = ir_data[n-5:0];
    assign seq_count = sc;

    timing_decoder u_timing (
        .sc (sc),
        .t  (t)
    );

    // Steps no instruction can legally reach are squashed and restart fetch.
    assign t_bad = (|t[15:7]) | (t[6] & (d != OP_ISZ));

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= RUN;
            sc    <= '0;
        end else begin
            state <= state_next;
            sc    <= sc_next;
        end
    end

    always_comb begin
        reg_write  = '0;
        reg_inc    = '0;
        reg_clear  = '0;
        bus_select = BUS_NONE;
        alu_op     = ALU_NONE;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        halted     = (state == HALTED);
        state_next = state;
        sc_next    = sc + 4'd1;

        if (clear) begin
            halted     = 1'b0;
            state_next = RUN;
            sc_next    = '0;
        end else if (state == HALTED) begin
            sc_next = '0;
            if (start) state_next = RUN;
        end else if (t_bad) begin
            sc_next = '0;
        end else if (t[0]) begin
            bus_select        = BUS_PC;
            reg_write[REG_AR] = 1'b1;
        end else if (t[1]) begin
            mem_read          = 1'b1;
            bus_select        = BUS_MEM;
            reg_write[REG_IR] = 1'b1;
            reg_inc[REG_PC]   = 1'b1;
        end else if (t[2]) begin
            bus_select        = BUS_IR;
            reg_write[REG_AR] = 1'b1;
        end else if (t[3]) begin
            if (d == OP_REG_IO) begin
                sc_next = '0;
                // Register-reference: only the highest set micro-op bit acts.
                if (!ind) begin
                    if (b[UOP_CLA])      reg_clear[REG_AC] = 1'b1;
                    else if (b[UOP_CLE]) alu_op = ALU_CME_CLE;
                    else if (b[UOP_CMA]) begin alu_op = ALU_CMA; reg_write[REG_AC] = 1'b1; end
                    else if (b[UOP_CME]) alu_op = ALU_CME_CLE;
                    else if (b[UOP_CIR]) begin alu_op = ALU_CIR; reg_write[REG_AC] = 1'b1; end
                    else if (b[UOP_CIL]) begin alu_op = ALU_CIL; reg_write[REG_AC] = 1'b1; end
                    else if (b[UOP_INC]) reg_inc[REG_AC] = 1'b1;
                    else if (b[UOP_SPA]) reg_inc[REG_PC] = !ac_sign;
                    else if (b[UOP_SNA]) reg_inc[REG_PC] = ac_sign;
                    else if (b[UOP_SZA]) reg_inc[REG_PC] = ac_zero;
                    else if (b[UOP_SZE]) reg_inc[REG_PC] = !e_flag;
                    else if (b[UOP_HLT]) state_next = HALTED;
                end
            end else if (ind) begin
                mem_read          = 1'b1;
                bus_select        = BUS_MEM;
                reg_write[REG_AR] = 1'b1;
            end
        end else if (t[4]) begin
            case (d)
                OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                    mem_read          = 1'b1;
                    bus_select        = BUS_MEM;
                    reg_write[REG_DR] = 1'b1;
                end
                OP_STA: begin
                    bus_select = BUS_AC;
                    mem_write  = 1'b1;
                    sc_next    = '0;
                end
                OP_BUN: begin
                    bus_select        = BUS_AR;
                    reg_write[REG_PC] = 1'b1;
                    sc_next           = '0;
                end
                OP_BSA: begin
                    bus_select      = BUS_PC;
                    mem_write       = 1'b1;
                    reg_inc[REG_AR] = 1'b1;
                end
                default: sc_next = '0;
            endcase
        end else if (t[5]) begin
            case (d)
                OP_AND, OP_ADD, OP_LDA: begin
                    alu_op            = (d == OP_AND) ? ALU_AND :
                                        (d == OP_ADD) ? ALU_ADD : ALU_LOAD_DR;
                    reg_write[REG_AC] = 1'b1;
                    sc_next           = '0;
                end
                OP_BSA: begin
                    bus_select        = BUS_AR;
                    reg_write[REG_PC] = 1'b1;
                    sc_next           = '0;
                end
                OP_ISZ:  reg_inc[REG_DR] = 1'b1;
                default: sc_next = '0;
            endcase
        end else if (t[6]) begin
            bus_select      = BUS_DR;
            mem_write       = 1'b1;
            reg_inc[REG_PC] = dr_zero;
            sc_next         = '0;
        end
    end

endmodule
